// File: rtl/pcs_receive.sv
`default_nettype none
// ============================================================================
//  Module   : pcs_receive
//  Purpose  : 1000BASE-X PCS receive path (reduced Fig 36-7 style machine).
//             Decodes aligned 10-bit code groups into GMII-style receive
//             signals. Autonegotiation /C/ ordered sets and carrier extension
//             are not supported.
//  Ports    : GTX_CLK        in   single clock, rising edge
//             mr_main_reset  in   asynchronous active-low reset
//             rx_code_group  in   [9]=a ... [0]=j, one aligned group per clock
//             sync_status    in   1 = synchronization reports link OK
//             RXD            out  decoded byte
//             RX_DV          out  receive data valid
//             RX_ER          out  receive error
//             receiving      out  carrier sense, /S/ cycle to end of frame
//  Revision : 1.0  initial release
// ============================================================================
module pcs_receive #(
    parameter logic [7:0] SOP_RXD = 8'h55,
    parameter logic [7:0] ERR_RXD = 8'h0E
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] rx_code_group,
    input  logic       sync_status,
    output logic [7:0] RXD,
    output logic       RX_DV,
    output logic       RX_ER,
    output logic       receiving
);

    // All-zero is not a legal code group, so it doubles as the flush value
    // that decodes as INVALID.
    localparam logic [9:0] CG_FLUSH   = 10'b0000000000;
    localparam logic [9:0] CG_R_NEG   = 10'b1110101000;
    localparam logic [9:0] CG_R_POS   = 10'b0001010111;

    typedef enum logic [2:0] {
        SYM_DATA    = 3'd0,
        SYM_K285    = 3'd1,
        SYM_R       = 3'd2,
        SYM_S       = 3'd3,
        SYM_T       = 3'd4,
        SYM_V       = 3'd5,
        SYM_INVALID = 3'd6
    } sym_kind_t;

    typedef struct packed {
        sym_kind_t  kind;
        logic [7:0] data;
    } sym_t;

    typedef enum logic [2:0] {
        LINK_FAILED = 3'd0,
        WAIT_FOR_K  = 3'd1,
        RX_K        = 3'd2,
        IDLE_D      = 3'd3,
        RECEIVE     = 3'd4,
        TRI_RRI     = 3'd5
    } state_t;

    // Both running-disparity columns are accepted; disparity is not tracked.
    function automatic sym_t decode(input logic [9:0] cg);
        sym_t s;
        s.kind = SYM_DATA;
        s.data = 8'h00;
        case (cg)
            10'b1001110100, 10'b0110001011: s.data = 8'h00;   // D0.0
            10'b0111010100, 10'b1000101011: s.data = 8'h01;   // D1.0
            10'b1011010100, 10'b0100101011: s.data = 8'h02;   // D2.0
            10'b1100011011, 10'b1100010100: s.data = 8'h03;   // D3.0
            10'b1011010101, 10'b0100100101: s.data = 8'h42;   // D2.2
            10'b0110110101, 10'b1001000101: s.data = 8'h50;   // D16.2
            10'b0101101101, 10'b0101100010: s.data = 8'h9A;   // D26.4
            10'b0110011010:                 s.data = 8'hA6;   // D6.5
            10'b1010101010:                 s.data = 8'hB5;   // D21.5
            10'b1010010110:                 s.data = 8'hC5;   // D5.6
            10'b0011111010, 10'b1100000101: s.kind = SYM_K285;
            CG_R_NEG, CG_R_POS:             s.kind = SYM_R;   // K23.7
            10'b1101101000, 10'b0010010111: s.kind = SYM_S;   // K27.7
            10'b1011101000, 10'b0100010111: s.kind = SYM_T;   // K29.7
            10'b0111101000, 10'b1000010111: s.kind = SYM_V;   // K30.7
            default:                        s.kind = SYM_INVALID;
        endcase
        return s;
    endfunction

    // Stage A is the one-group lookahead, stage B the group being evaluated.
    logic [9:0] cg_a;
    logic [9:0] cg_b;
    sym_t       sym_b;
    logic       a_is_r;

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            cg_a <= CG_FLUSH;
            cg_b <= CG_FLUSH;
        end else if (!sync_status) begin
            cg_a <= CG_FLUSH;
            cg_b <= CG_FLUSH;
        end else begin
            cg_a <= rx_code_group;
            cg_b <= cg_a;
        end
    end

    assign sym_b  = decode(cg_b);
    assign a_is_r = (cg_a == CG_R_NEG) || (cg_a == CG_R_POS);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rxd_nxt;
    logic       dv_nxt;
    logic       er_nxt;
    logic       rcv_nxt;

    // START_OF_PACKET, RX_DATA_ERROR and EARLY_END last exactly one group,
    // so they are produced as transition outputs rather than held states.
    always_comb begin
        state_nxt = state;
        rxd_nxt   = 8'h00;
        dv_nxt    = 1'b0;
        er_nxt    = 1'b0;
        rcv_nxt   = 1'b0;
        if (!sync_status) begin
            state_nxt = LINK_FAILED;
            // Flag the lost frame once; receiving drops on the same edge so
            // this cannot repeat while the link stays down.
            if (receiving) begin
                er_nxt  = 1'b1;
                rxd_nxt = ERR_RXD;
            end
        end else begin
            case (state)
                LINK_FAILED: state_nxt = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (sym_b.kind == SYM_K285) state_nxt = RX_K;
                end
                RX_K: begin
                    if ((sym_b.kind == SYM_DATA) &&
                        ((sym_b.data == 8'h50) || (sym_b.data == 8'hC5)))
                        state_nxt = IDLE_D;
                    else
                        state_nxt = WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (sym_b.kind == SYM_K285) begin
                        state_nxt = RX_K;
                    end else if (sym_b.kind == SYM_S) begin
                        state_nxt = RECEIVE;
                        rxd_nxt   = SOP_RXD;
                        dv_nxt    = 1'b1;
                        rcv_nxt   = 1'b1;
                    end else begin
                        state_nxt = WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    rcv_nxt = 1'b1;
                    case (sym_b.kind)
                        SYM_DATA: begin
                            rxd_nxt = sym_b.data;
                            dv_nxt  = 1'b1;
                        end
                        SYM_T: begin
                            if (a_is_r) begin
                                state_nxt = TRI_RRI;
                                rcv_nxt   = 1'b0;
                            end else begin
                                rxd_nxt = ERR_RXD;
                                dv_nxt  = 1'b1;
                                er_nxt  = 1'b1;
                            end
                        end
                        SYM_K285: begin
                            state_nxt = RX_K;
                            rxd_nxt   = ERR_RXD;
                            dv_nxt    = 1'b1;
                            er_nxt    = 1'b1;
                            rcv_nxt   = 1'b0;
                        end
                        default: begin
                            rxd_nxt = ERR_RXD;
                            dv_nxt  = 1'b1;
                            er_nxt  = 1'b1;
                        end
                    endcase
                end
                TRI_RRI: begin
                    if (sym_b.kind == SYM_R)
                        state_nxt = TRI_RRI;
                    else if (sym_b.kind == SYM_K285)
                        state_nxt = RX_K;
                    else
                        state_nxt = WAIT_FOR_K;
                end
                default: state_nxt = LINK_FAILED;
            endcase
        end
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state     <= LINK_FAILED;
            RXD       <= 8'h00;
            RX_DV     <= 1'b0;
            RX_ER     <= 1'b0;
            receiving <= 1'b0;
        end else begin
            state     <= state_nxt;
            RXD       <= rxd_nxt;
            RX_DV     <= dv_nxt;
            RX_ER     <= er_nxt;
            receiving <= rcv_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcs_receive.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcs_receive
//  Purpose  : Scoreboard bench for pcs_receive. A symbol-level reference
//             model predicts every output cycle; a monitor compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcs_receive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cg;
    logic       sync;
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    logic       rcv;

    always #5 clk = ~clk;

    pcs_receive dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst_n),
        .rx_code_group (cg),
        .sync_status   (sync),
        .RXD           (rxd),
        .RX_DV         (dv),
        .RX_ER         (er),
        .receiving     (rcv)
    );

    typedef struct packed {
        logic [7:0] rxd;
        logic       dv;
        logic       er;
        logic       rcv;
    } obs_t;

    // Symbol ids: 0..255 are data bytes, specials above, -1 invalid.
    localparam int K   = 256;
    localparam int R   = 257;
    localparam int S   = 258;
    localparam int T   = 259;
    localparam int V   = 260;
    localparam int INV = -1;

    localparam int M_DOWN  = 0;
    localparam int M_HUNT  = 1;
    localparam int M_GOTK  = 2;
    localparam int M_IDLE  = 3;
    localparam int M_FRAME = 4;
    localparam int M_TAIL  = 5;

    bit [9:0] tab [2][261];
    int       sym_of [1024];
    int       dsyms [10] = '{'h00, 'h01, 'h02, 'h03, 'h42, 'h50, 'h9A, 'hA6, 'hB5, 'hC5};

    obs_t       exp_q [$];
    logic [7:0] cap_q [$];
    logic [7:0] want_q [$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    bit  cap_en = 1'b0;
    int  cap_er, cap_er_nodv, cap_rcv;
    int  col_mode = 0;

    int  m_mode;
    int  ma, mb;
    bit  m_rcv;

    task automatic add_sym(input int sym, input bit [9:0] m, input bit [9:0] p);
        tab[0][sym] = m;
        tab[1][sym] = p;
        sym_of[m]   = sym;
        sym_of[p]   = sym;
    endtask

    task automatic model_reset();
        m_mode = M_DOWN;
        ma     = INV;
        mb     = INV;
        m_rcv  = 1'b0;
    endtask

    // Predicts the outputs after the edge that samples (grp, s).
    task automatic model_step(input bit [9:0] grp, input bit s);
        obs_t o;
        int   b;
        o = '0;
        b = mb;
        if (!s) begin
            if (m_rcv) begin
                o.er  = 1'b1;
                o.rxd = 8'h0E;
            end
            m_mode = M_DOWN;
        end else begin
            case (m_mode)
                M_DOWN: m_mode = M_HUNT;
                M_HUNT: if (b == K) m_mode = M_GOTK;
                M_GOTK: m_mode = (b == 'h50 || b == 'hC5) ? M_IDLE : M_HUNT;
                M_IDLE: begin
                    if (b == K) m_mode = M_GOTK;
                    else if (b == S) begin
                        o.rxd = 8'h55; o.dv = 1'b1; o.rcv = 1'b1;
                        m_mode = M_FRAME;
                    end else m_mode = M_HUNT;
                end
                M_FRAME: begin
                    if (b >= 0 && b < 256) begin
                        o.rxd = 8'(b); o.dv = 1'b1; o.rcv = 1'b1;
                    end else if (b == T && ma == R) begin
                        m_mode = M_TAIL;
                    end else if (b == K) begin
                        o.rxd = 8'h0E; o.dv = 1'b1; o.er = 1'b1;
                        m_mode = M_GOTK;
                    end else begin
                        o.rxd = 8'h0E; o.dv = 1'b1; o.er = 1'b1; o.rcv = 1'b1;
                    end
                end
                default: begin
                    if (b == K) m_mode = M_GOTK;
                    else if (b != R) m_mode = M_HUNT;
                end
            endcase
        end
        exp_q.push_back(o);
        m_rcv = o.rcv;
        mb    = s ? ma : INV;
        ma    = s ? sym_of[grp] : INV;
    endtask

    function automatic bit [9:0] enc(input int sym);
        bit [9:0] c;
        int       col;
        if (sym == INV) begin
            do c = 10'($urandom_range(0, 1023)); while (sym_of[c] != INV);
            return c;
        end
        col = (col_mode == 2) ? int'($urandom_range(0, 1)) : col_mode;
        return tab[col][sym];
    endfunction

    task automatic drive_now(input bit [9:0] c, input bit s);
        cg   = c;
        sync = s;
        model_step(c, s);
    endtask

    task automatic drive(input bit [9:0] c, input bit s);
        @(negedge clk);
        drive_now(c, s);
    endtask

    task automatic send(input int sym);
        drive(enc(sym), 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            send(K);
            send(($urandom_range(0, 1) == 1) ? 'h50 : 'hC5);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rxd, dv, er, rcv} !== 11'd0) begin
            failures++;
            $display("FAIL %s got rxd=%h dv=%b er=%b rcv=%b required all zero", name, rxd, dv, er, rcv);
        end
        exp_q.delete();
        model_reset();
        cg   = '0;
        sync = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drive_now(10'd0, 1'b0);
    endtask

    task automatic cap_begin();
        cap_q.delete();
        want_q.delete();
        cap_er      = 0;
        cap_er_nodv = 0;
        cap_rcv     = 0;
        cap_en      = 1'b1;
    endtask

    task automatic want(input logic [7:0] b);
        want_q.push_back(b);
    endtask

    task automatic cap_end(input string name, input int n_er, input int n_er_nodv, input int n_rcv);
        idle(2);
        cap_en = 1'b0;
        checks++;
        if (cap_q.size() != want_q.size()) begin
            failures++;
            $display("FAIL %s_len got %0d bytes required %0d", name, cap_q.size(), want_q.size());
        end else begin
            for (int i = 0; i < want_q.size(); i++) begin
                checks++;
                if (cap_q[i] !== want_q[i]) begin
                    failures++;
                    $display("FAIL %s_byte%0d got %h required %h", name, i, cap_q[i], want_q[i]);
                end
            end
        end
        checks++;
        if (cap_er != n_er) begin
            failures++;
            $display("FAIL %s_er_cycles got %0d required %0d", name, cap_er, n_er);
        end
        checks++;
        if (cap_er_nodv != n_er_nodv) begin
            failures++;
            $display("FAIL %s_er_without_dv got %0d required %0d", name, cap_er_nodv, n_er_nodv);
        end
        checks++;
        if (cap_rcv != n_rcv) begin
            failures++;
            $display("FAIL %s_receiving_cycles got %0d required %0d", name, cap_rcv, n_rcv);
        end
    endtask

    // Monitor: outputs are registered, so every edge presents one result.
    always @(posedge clk) begin : monitor
        obs_t e_o;
        obs_t g_o;
        #1;
        if (mon_en && exp_q.size() > 0) begin
            e_o = exp_q.pop_front();
            g_o = {rxd, dv, er, rcv};
            checks++;
            if (g_o !== e_o) begin
                failures++;
                $display("FAIL scoreboard t=%0t got rxd=%h dv=%b er=%b rcv=%b required rxd=%h dv=%b er=%b rcv=%b",
                         $time, g_o.rxd, g_o.dv, g_o.er, g_o.rcv, e_o.rxd, e_o.dv, e_o.er, e_o.rcv);
            end
            if (cap_en) begin
                if (dv) cap_q.push_back(rxd);
                if (er) cap_er++;
                if (er && !dv) cap_er_nodv++;
                if (rcv) cap_rcv++;
            end
        end
    end

    initial begin : stim
        int len, endk, r, n;
        rst_n = 1'b1;
        cg    = '0;
        sync  = 1'b0;
        for (int i = 0; i < 1024; i++) sym_of[i] = INV;
        add_sym('h00, 10'b1001110100, 10'b0110001011);
        add_sym('h01, 10'b0111010100, 10'b1000101011);
        add_sym('h02, 10'b1011010100, 10'b0100101011);
        add_sym('h03, 10'b1100011011, 10'b1100010100);
        add_sym('h42, 10'b1011010101, 10'b0100100101);
        add_sym('h50, 10'b0110110101, 10'b1001000101);
        add_sym('h9A, 10'b0101101101, 10'b0101100010);
        add_sym('hA6, 10'b0110011010, 10'b0110011010);
        add_sym('hB5, 10'b1010101010, 10'b1010101010);
        add_sym('hC5, 10'b1010010110, 10'b1010010110);
        add_sym(K,    10'b0011111010, 10'b1100000101);
        add_sym(R,    10'b1110101000, 10'b0001010111);
        add_sym(S,    10'b1101101000, 10'b0010010111);
        add_sym(T,    10'b1011101000, 10'b0100010111);
        add_sym(V,    10'b0111101000, 10'b1000010111);

        do_reset("reset_state");

        // 1: idle acquisition
        col_mode = 0;
        repeat (4) begin send(K); send('h50); end

        // 2: normal frame
        cap_begin();
        send(S); send('h00); send('hB5); send('hC5); send(T); send(R); send(K); send('h50);
        want('h55); want('h00); want('hB5); want('hC5);
        cap_end("frame_basic", 0, 0, 4);

        // 3: /V/ inside frame
        idle(1);
        cap_begin();
        send(S); send('h00); send(V); send('hB5); send(T); send(R); send(K); send('h50);
        want('h55); want('h00); want('h0E); want('hB5);
        cap_end("frame_v", 1, 0, 4);

        // 4: K28.5 in place of /T/
        idle(1);
        cap_begin();
        send(S); send('h00); send('h03); send(K); send('h50);
        want('h55); want('h00); want('h03); want('h0E);
        cap_end("early_end", 1, 0, 3);

        // 5: link loss mid-frame, then stream without idle must stay silent
        idle(1);
        cap_begin();
        send(S); send('h00); send('h01); send('h02); send('h03);
        repeat (3) drive(enc('h9A), 1'b0);
        send(S); send('h00); send('h01); send(T); send(R);
        want('h55); want('h00); want('h01);
        cap_end("link_loss", 1, 1, 3);
        idle(1);
        cap_begin();
        send(S); send('h42); send(T); send(R); send(K); send('hC5);
        want('h55); want('h42);
        cap_end("reacquire", 0, 0, 2);

        // 6: RD+ column
        col_mode = 1;
        idle(1);
        cap_begin();
        send(S); send('h00); send('hB5); send('hC5); send(T); send(R); send(K); send('h50);
        want('h55); want('h00); want('hB5); want('hC5);
        cap_end("frame_rdplus", 0, 0, 4);

        // asynchronous reset in the middle of a frame
        idle(1);
        send(S); send('h00); send('h01); send('h02);
        do_reset("async_reset_midframe");
        col_mode = 2;
        idle(3);

        // randomized frames and corruptions
        for (int f = 0; f < 60; f++) begin
            len  = $urandom_range(1, 8);
            endk = $urandom_range(0, 9);
            idle($urandom_range(1, 3));
            send(S);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      send(V);
                else if (r == 1) send(INV);
                else if (r == 2) send(R);
                else             send(dsyms[$urandom_range(0, 9)]);
            end
            if (endk < 6) begin
                send(T); send(R);
                if ($urandom_range(0, 1) == 1) send(R);
            end else if (endk == 6) begin
                send(T); send(dsyms[$urandom_range(0, 9)]); send(T); send(R);
            end else if (endk == 7) begin
                send(K);
            end else begin
                n = $urandom_range(1, 3);
                repeat (n) drive(enc(dsyms[0]), 1'b0);
            end
        end
        idle(3);
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
